// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for branch prediction resolution
//
// Contents:
//   PC_WIDTH_DEFAULT  default PC/target width
//   pred_info_t       {taken, target} carried alongside each instruction
//   PRED_CLEAR        bubble value (not taken, target 0), can never mispredict
//   mispred_cause_e   classification of a mispredict, used for debug visibility
package bp_pkg;

  localparam int PC_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic                        taken;
    logic [PC_WIDTH_DEFAULT-1:0] target;
  } pred_info_t;

  localparam pred_info_t PRED_CLEAR = '{taken: 1'b0, target: '0};

  typedef enum logic [2:0] {
    NONE,
    ALIAS,
    NOT_TAKEN,
    TAKEN,
    TARGET
  } mispred_cause_e;

endpackage

// File: rtl/pred_stage_reg.sv
// rtl/pred_stage_reg.sv - one pipeline register for prediction info with stall/flush
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous reset, active-low
//   stall_i  hold current contents
//   flush_i  load the clear value (wins over stall)
//   d_i      next prediction
//   q_o      registered prediction
module pred_stage_reg
  import bp_pkg::*;
#(
  parameter type   pred_t = pred_info_t,
  parameter pred_t CLEAR  = PRED_CLEAR
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  stall_i,
  input  logic  flush_i,
  input  pred_t d_i,
  output pred_t q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      q_o <= CLEAR;
    end else if (!stall_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - carries F-stage predictions to E, resolves them, drives predictor update
//
// Optional feature macro: BRANCH_STATS_EN (resolved-branch and mispredict counters).
//
// Ports:
//   clk_i, rst_ni                         clock, synchronous active-low reset
//   predictTakenF_i, predictTargetF_i     prediction for the instruction in F
//   stallD_i, flushD_i                    F->D register hold / clear
//   stallE_i, flushE_i                    D->E register hold / clear
//   PCE_i, BranchE_i, JumpE_i, JalrE_i,   actual outcome of the instruction in E
//   TakenE_i, PCTargetE_i
//   mispredictE_o, redirectPCE_o          redirect request and the correct next PC
//   updEnE_o, updTakenE_o, updTargetE_o,  predictor update interface
//   updPCE_o
//   branchCount_o, mispredCount_o         statistics (zero when BRANCH_STATS_EN undefined)
module branch_resolve
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                predictTakenF_i,
  input  logic [PC_WIDTH-1:0] predictTargetF_i,
  input  logic                stallD_i,
  input  logic                flushD_i,
  input  logic                stallE_i,
  input  logic                flushE_i,
  input  logic [PC_WIDTH-1:0] PCE_i,
  input  logic                BranchE_i,
  input  logic                JumpE_i,
  input  logic                JalrE_i,
  input  logic                TakenE_i,
  input  logic [PC_WIDTH-1:0] PCTargetE_i,
  output logic                mispredictE_o,
  output logic [PC_WIDTH-1:0] redirectPCE_o,
  output logic                updEnE_o,
  output logic                updTakenE_o,
  output logic [PC_WIDTH-1:0] updTargetE_o,
  output logic [PC_WIDTH-1:0] updPCE_o,
  output logic [31:0]         branchCount_o,
  output logic [31:0]         mispredCount_o
);

  // Local struct so the register width tracks PC_WIDTH rather than the package default.
  typedef struct packed {
    logic                taken;
    logic [PC_WIDTH-1:0] target;
  } pred_w_t;

  localparam pred_w_t PRED_NONE = '{taken: 1'b0, target: '0};

  pred_w_t        pred_f;
  pred_w_t        pred_d;
  pred_w_t        pred_e;
  logic           actual_taken;
  logic           is_ctrl;
  logic [PC_WIDTH-1:0] pc_plus4;
  mispred_cause_e cause;

  assign pred_f = '{taken: predictTakenF_i, target: predictTargetF_i};

  // A mispredict squashes the younger instructions in D and E on the next edge.
  pred_stage_reg #(.pred_t(pred_w_t), .CLEAR(PRED_NONE)) u_pred_d (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stallD_i),
    .flush_i (flushD_i | mispredictE_o),
    .d_i     (pred_f),
    .q_o     (pred_d)
  );

  pred_stage_reg #(.pred_t(pred_w_t), .CLEAR(PRED_NONE)) u_pred_e (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stallE_i),
    .flush_i (flushE_i | mispredictE_o),
    .d_i     (pred_d),
    .q_o     (pred_e)
  );

  always_comb begin
    actual_taken = JumpE_i | JalrE_i | (BranchE_i & TakenE_i);
    is_ctrl      = BranchE_i | JumpE_i | JalrE_i;
    pc_plus4     = PCE_i + PC_WIDTH'(4);
    cause        = NONE;
    if (pred_e.taken && !is_ctrl) begin
      cause = ALIAS;
    end else if (pred_e.taken && BranchE_i && !TakenE_i) begin
      cause = NOT_TAKEN;
    end else if (actual_taken && !pred_e.taken) begin
      cause = TAKEN;
    end else if (actual_taken && pred_e.target != PCTargetE_i) begin
      cause = TARGET;
    end
  end

  assign mispredictE_o = (cause != NONE);
  assign redirectPCE_o = (cause == TAKEN || cause == TARGET) ? PCTargetE_i : pc_plus4;

  // JALR targets are register dependent, so the predictor is never trained on them.
  assign updEnE_o     = BranchE_i | JumpE_i;
  assign updTakenE_o  = actual_taken;
  assign updTargetE_o = PCTargetE_i;
  assign updPCE_o     = PCE_i;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  // A stalled E stage repeats the same instruction; count it only once it moves on.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (updEnE_o && !stallE_i && branch_cnt != '1) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredictE_o && !stallE_i && mispred_cnt != '1) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  assign branchCount_o  = branch_cnt;
  assign mispredCount_o = mispred_cnt;
`else
  assign branchCount_o  = '0;
  assign mispredCount_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve with directed vectors
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_tk_f;
  logic [31:0] pred_tgt_f;
  logic        stall_d, flush_d, stall_e, flush_e;
  logic [31:0] pce;
  logic        br_e, j_e, jr_e, tk_e;
  logic [31:0] tgt_e;
  logic        mis;
  logic [31:0] redir;
  logic        upd_en, upd_tk;
  logic [31:0] upd_tgt, upd_pc, bcnt, mcnt;

  always #5 clk = ~clk;

  branch_resolve #(.PC_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .predictTakenF_i  (pred_tk_f),
    .predictTargetF_i (pred_tgt_f),
    .stallD_i         (stall_d),
    .flushD_i         (flush_d),
    .stallE_i         (stall_e),
    .flushE_i         (flush_e),
    .PCE_i            (pce),
    .BranchE_i        (br_e),
    .JumpE_i          (j_e),
    .JalrE_i          (jr_e),
    .TakenE_i         (tk_e),
    .PCTargetE_i      (tgt_e),
    .mispredictE_o    (mis),
    .redirectPCE_o    (redir),
    .updEnE_o         (upd_en),
    .updTakenE_o      (upd_tk),
    .updTargetE_o     (upd_tgt),
    .updPCE_o         (upd_pc),
    .branchCount_o    (bcnt),
    .mispredCount_o   (mcnt)
  );

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        mis;
    logic [31:0] red;
    logic        en;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is consumed per cycle away from the edge.
  exp_t e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "mispredict", {31'd0, mis},    {31'd0, e.mis});
      chk(e.nm, "redirect",   redir,           e.red);
      chk(e.nm, "upd_en",     {31'd0, upd_en}, {31'd0, e.en});
      chk(e.nm, "upd_taken",  {31'd0, upd_tk}, {31'd0, e.tk});
      chk(e.nm, "upd_target", upd_tgt,         e.tgt);
      chk(e.nm, "upd_pc",     upd_pc,          e.pc);
      chk(e.nm, "branch_cnt", bcnt,            e.bc);
      chk(e.nm, "mispred_cnt", mcnt,           e.mc);
    end
  end

  task automatic push(input string nm, input logic m, input logic [31:0] red, input logic en,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] pc,
                      input logic [31:0] bc, input logic [31:0] mc);
    exp_t x;
    x.nm = nm; x.mis = m; x.red = red; x.en = en; x.tk = tk; x.tgt = tgt; x.pc = pc;
    x.bc = STATS ? bc : 32'd0;
    x.mc = STATS ? mc : 32'd0;
    sb.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fpred(input logic tk, input logic [31:0] tgt);
    pred_tk_f  = tk;
    pred_tgt_f = tgt;
  endtask

  task automatic eset(input logic [31:0] pc, input logic br, input logic j, input logic jr,
                      input logic tk, input logic [31:0] tgt);
    pce = pc; br_e = br; j_e = j; jr_e = jr; tk_e = tk; tgt_e = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    stall_d = 0; flush_d = 0; stall_e = 0; flush_e = 0;
    fpred(0, 0);
    eset(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    eset(32'h10, 0, 0, 0, 0, 0);
    push("reset", 0, 32'h14, 0, 0, 0, 32'h10, 0, 0);

    // Correct taken prediction
    cyc(); rst_n = 1'b1; fpred(1, 32'h100); eset(0, 0, 0, 0, 0, 0);
    cyc(); fpred(0, 0);
    cyc(); eset(32'h40, 1, 0, 0, 1, 32'h100);
    push("correct_taken", 0, 32'h44, 1, 1, 32'h100, 32'h40, 0, 0);

    // Predicted not taken, branch taken; younger taken prediction in F must be squashed
    cyc(); eset(32'h20, 1, 0, 0, 1, 32'h80); fpred(1, 32'h600);
    push("wrong_not_taken", 1, 32'h80, 1, 1, 32'h80, 32'h20, 1, 0);
    cyc(); fpred(0, 0); eset(32'h50, 0, 0, 0, 0, 0);
    push("post_flush_e", 0, 32'h54, 0, 0, 0, 32'h50, 2, 1);
    cyc(); eset(32'h60, 0, 0, 0, 0, 0);
    push("post_flush_d", 0, 32'h64, 0, 0, 0, 32'h60, 2, 1);

    // Alias: taken prediction on a non-control instruction
    fpred(1, 32'h200);
    cyc(); fpred(0, 0);
    cyc(); eset(32'h30, 0, 0, 0, 0, 0);
    push("alias", 1, 32'h34, 0, 0, 0, 32'h30, 2, 1);

    // JALR target mismatch
    cyc(); fpred(1, 32'h300); eset(0, 0, 0, 0, 0, 0);
    cyc(); fpred(0, 0);
    cyc(); eset(32'h70, 0, 0, 1, 0, 32'h310);
    push("jalr_target", 1, 32'h310, 0, 1, 32'h310, 32'h70, 2, 2);

    // Stall E for three edges with a correctly predicted branch
    cyc(); fpred(1, 32'h140); eset(0, 0, 0, 0, 0, 0);
    cyc(); fpred(0, 0);
    cyc(); eset(32'h90, 1, 0, 0, 1, 32'h140); stall_e = 1;
    push("stall_0", 0, 32'h94, 1, 1, 32'h140, 32'h90, 2, 3);
    cyc(); push("stall_1", 0, 32'h94, 1, 1, 32'h140, 32'h90, 2, 3);
    cyc(); push("stall_2", 0, 32'h94, 1, 1, 32'h140, 32'h90, 2, 3);
    cyc(); stall_e = 0;
    push("stall_release", 0, 32'h94, 1, 1, 32'h140, 32'h90, 2, 3);
    cyc(); eset(32'h100, 0, 0, 0, 0, 0);
    push("stall_counted", 0, 32'h104, 0, 0, 0, 32'h100, 3, 3);

    // flushD beats stallD
    fpred(1, 32'h700);
    cyc(); stall_d = 1; flush_d = 1; stall_e = 1;
    cyc(); stall_d = 0; flush_d = 0; stall_e = 0; fpred(0, 0);
    cyc(); eset(32'hA0, 0, 0, 0, 0, 0);
    push("flush_d_over_stall", 0, 32'hA4, 0, 0, 0, 32'hA0, 3, 3);

    // flushE beats stallE
    fpred(1, 32'h800);
    cyc(); fpred(0, 0);
    cyc(); eset(32'hB0, 0, 1, 0, 0, 32'h800); stall_e = 1; flush_e = 1;
    push("jal_correct", 0, 32'hB4, 1, 1, 32'h800, 32'hB0, 3, 3);
    cyc(); stall_e = 0; flush_e = 0; eset(32'hC0, 0, 0, 0, 0, 0);
    push("flush_e_over_stall", 0, 32'hC4, 0, 0, 0, 32'hC0, 3, 3);

    // Reset with taken predictions in flight in D and E
    fpred(1, 32'h900);
    cyc();
    cyc(); eset(32'hC8, 0, 1, 0, 0, 32'h900); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; fpred(0, 0); eset(32'hD0, 0, 0, 0, 0, 0);
    push("reset_mid_e", 0, 32'hD4, 0, 0, 0, 32'hD0, 0, 0);
    cyc(); eset(32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    push("reset_mid_d_wrap", 0, 32'h0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);

    cyc(); cyc();
    chk("scoreboard", "drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
